clkdiv_multi: RTL and testbench

Parametrised multi-channel clock divider for the VGA display path. Generates NUM_CH independent divided clocks plus one-cycle clock-enable strobes from a single reference clock. Divisors are reprogrammable at run time through a valid/ready write port, and changes are applied glitch-free at period boundaries. A `locked` flag reports that every channel has run LOCK_PERIODS full periods at its current divisor.

---
 rtl/clkdiv_multi.sv | 112 +++++++++++
 tb/tb_clkdiv_multi.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider with per-channel clock-enable strobes,
// a single-slot divisor write port applied at period boundaries, and a lock flag.
module clkdiv_multi #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned DIV_INIT     = 2,
  parameter int unsigned LOCK_PERIODS = 4,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk_i,
  input  logic              rst_ni,
  input  logic              div_valid_i,
  input  logic [CH_W-1:0]   div_ch_i,
  input  logic [DIV_W-1:0]  div_value_i,
  output logic              div_ready_o,
  output logic [NUM_CH-1:0] ce_out_o,
  output logic [NUM_CH-1:0] outclk_o,
  output logic              locked_o
);

  localparam int unsigned      LcW     = $clog2(LOCK_PERIODS + 1);
  localparam logic [DIV_W-1:0] One     = DIV_W'(1);
  localparam logic [DIV_W-1:0] Two     = DIV_W'(2);
  localparam logic [DIV_W-1:0] DivInit = (DIV_INIT < 2) ? Two : DIV_W'(DIV_INIT);
  localparam logic [LcW-1:0]   LcMax   = LcW'(LOCK_PERIODS);
  localparam logic [CH_W:0]    NumCh   = (CH_W + 1)'(NUM_CH);

  logic [DIV_W-1:0] cnt_q [NUM_CH];
  logic [DIV_W-1:0] cnt_d [NUM_CH];
  logic [DIV_W-1:0] div_q [NUM_CH];
  logic [DIV_W-1:0] div_d [NUM_CH];
  logic [LcW-1:0]   lc_q  [NUM_CH];
  logic [LcW-1:0]   lc_d  [NUM_CH];
  logic [DIV_W-1:0] nxt   [NUM_CH];

  logic [NUM_CH-1:0] ce_q, ce_d, outclk_q, outclk_d, apply;
  logic              p_valid_q, p_valid_d;
  logic [CH_W-1:0]   p_ch_q, p_ch_d;
  logic [DIV_W-1:0]  p_val_q, p_val_d;
  logic              ready_q, ready_d, locked_q, locked_d;
  logic              accept, all_lc;

  always_comb begin
    p_valid_d = p_valid_q;
    p_ch_d    = p_ch_q;
    p_val_d   = p_val_q;
    accept    = div_valid_i && ready_q;
    all_lc    = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      nxt[i]   = (cnt_q[i] == div_q[i] - One) ? '0 : cnt_q[i] + One;
      // p_valid_q is still low on the accepting edge, so a boundary there does not apply.
      apply[i] = p_valid_q && (p_ch_q == CH_W'(i)) && (nxt[i] == '0);
      div_d[i] = apply[i] ? p_val_q : div_q[i];
      cnt_d[i] = nxt[i];
      ce_d[i]  = (nxt[i] == '0);
      outclk_d[i] = nxt[i] < (div_d[i] >> 1);
      if (apply[i]) begin
        lc_d[i] = '0;
      end else if ((nxt[i] == '0) && (lc_q[i] < LcMax)) begin
        lc_d[i] = lc_q[i] + LcW'(1);
      end else begin
        lc_d[i] = lc_q[i];
      end
      all_lc = all_lc && (lc_d[i] == LcMax);
    end
    if (|apply) p_valid_d = 1'b0;
    // Out-of-range channel writes are consumed without occupying the slot.
    if (accept && ({1'b0, div_ch_i} < NumCh)) begin
      p_valid_d = 1'b1;
      p_ch_d    = div_ch_i;
      p_val_d   = (div_value_i < Two) ? Two : div_value_i;
    end
    ready_d  = !p_valid_d;
    locked_d = all_lc && !p_valid_d;
  end

  always_ff @(posedge refclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DivInit;
        lc_q[i]  <= '0;
      end
      ce_q      <= '0;
      outclk_q  <= '0;
      p_valid_q <= 1'b0;
      p_ch_q    <= '0;
      p_val_q   <= DivInit;
      ready_q   <= 1'b1;
      locked_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
        lc_q[i]  <= lc_d[i];
      end
      ce_q      <= ce_d;
      outclk_q  <= outclk_d;
      p_valid_q <= p_valid_d;
      p_ch_q    <= p_ch_d;
      p_val_q   <= p_val_d;
      ready_q   <= ready_d;
      locked_q  <= locked_d;
    end
  end

  assign div_ready_o = ready_q;
  assign ce_out_o    = ce_q;
  assign outclk_o    = outclk_q;
  assign locked_o    = locked_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi: reset, run-time divisor writes, clamping,
// out-of-range writes, back-to-back requests and asynchronous reset with a pending write.
module tb_clkdiv_multi;

  localparam int unsigned NumCh = 3;
  localparam int unsigned DivW  = 16;
  localparam int unsigned ChW   = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             div_valid;
  logic [ChW-1:0]   div_ch;
  logic [DivW-1:0]  div_value;
  logic             div_ready;
  logic [NumCh-1:0] ce_out, outclk;
  logic             locked;

  int e = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clkdiv_multi #(
    .NUM_CH      (NumCh),
    .DIV_W       (DivW),
    .DIV_INIT    (2),
    .LOCK_PERIODS(4)
  ) dut (
    .refclk_i   (clk),
    .rst_ni     (rst_n),
    .div_valid_i(div_valid),
    .div_ch_i   (div_ch),
    .div_value_i(div_value),
    .div_ready_o(div_ready),
    .ce_out_o   (ce_out),
    .outclk_o   (outclk),
    .locked_o   (locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    e++;
    @(negedge clk);
  endtask

  // {ce, outclk} after edge ee for a channel whose current period started at edge b with divisor d.
  function automatic logic [1:0] ph(input int ee, input int b, input int d);
    int p;
    p = (((ee - b) % d) + d) % d;
    return {p == 0, p < (d / 2)};
  endfunction

  task automatic chk_ch(input int ch, input logic [1:0] exp);
    check($sformatf("ce%0d@%0d", ch, e), ce_out[ch], exp[1]);
    check($sformatf("outclk%0d@%0d", ch, e), outclk[ch], exp[0]);
  endtask

  function automatic logic [DivW-1:0] burst_val(input int ee);
    case (ee)
      81:      return 16'd3;
      83:      return 16'd4;
      86:      return 16'd2;
      90:      return 16'd2;
      default: return 16'd9;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    div_valid = 1'b0;
    div_ch = '0;
    div_value = '0;
    repeat (3) @(negedge clk);
    check("rst_ce", 32'(ce_out), 0);
    check("rst_outclk", 32'(outclk), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_ready", 32'(div_ready), 1);

    // Reset release: all channels at D=2, lock after edge 8.
    rst_n = 1'b1;
    e = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      for (int c = 0; c < NumCh; c++) chk_ch(c, ph(e, 0, 2));
      check($sformatf("locked@%0d", e), 32'(locked), 32'(e >= 8));
      check($sformatf("ready@%0d", e), 32'(div_ready), 1);
    end

    // ch1 <- 5, accepted at edge 11, applied at boundary 12, relock at 32.
    div_valid = 1'b1; div_ch = 2'd1; div_value = 16'd5;
    for (int k = 11; k <= 34; k++) begin
      tick();
      div_valid = 1'b0;
      chk_ch(0, ph(e, 0, 2));
      chk_ch(1, (e < 12) ? ph(e, 0, 2) : ph(e, 12, 5));
      chk_ch(2, ph(e, 0, 2));
      check($sformatf("ready@%0d", e), 32'(div_ready), 32'(e != 11));
      check($sformatf("locked@%0d", e), 32'(locked), 32'(e >= 32));
    end

    // ch0 <- 4 (applied 36), then ch0 <- 6 accepted on boundary 40, applied 44.
    div_valid = 1'b1; div_ch = 2'd0; div_value = 16'd4;
    for (int k = 35; k <= 58; k++) begin
      tick();
      if (e < 36) chk_ch(0, ph(e, 0, 2));
      else if (e < 44) chk_ch(0, ph(e, 36, 4));
      else chk_ch(0, ph(e, 44, 6));
      chk_ch(1, ph(e, 12, 5));
      chk_ch(2, ph(e, 0, 2));
      check($sformatf("ready@%0d", e), 32'(div_ready),
            32'(!(e == 35 || (e >= 40 && e <= 43))));
      check($sformatf("locked@%0d", e), 32'(locked), 0);
      div_valid = (e == 39);
      div_value = 16'd6;
    end

    // Clamp: ch2 <- 0 (edge 59), ch2 <- 1 (edge 64); out-of-range ch3 at edge 76 while locked.
    div_valid = 1'b1; div_ch = 2'd2; div_value = 16'd0;
    for (int k = 59; k <= 80; k++) begin
      tick();
      chk_ch(0, ph(e, 44, 6));
      chk_ch(1, ph(e, 12, 5));
      chk_ch(2, ph(e, 0, 2));
      check($sformatf("ready@%0d", e), 32'(div_ready), 32'(!(e == 59 || e == 64 || e == 65)));
      check($sformatf("locked@%0d", e), 32'(locked), 32'(e >= 74));
      div_valid = (e == 63) || (e == 75);
      div_ch    = (e == 75) ? 2'd3 : 2'd2;
      div_value = (e == 75) ? 16'd7 : 16'd1;
    end

    // div_valid held high on ch2 with a new value every cycle.
    div_valid = 1'b1; div_ch = 2'd2; div_value = burst_val(81);
    for (int k = 81; k <= 94; k++) begin
      tick();
      chk_ch(0, ph(e, 44, 6));
      chk_ch(1, ph(e, 12, 5));
      if (e < 82) chk_ch(2, ph(e, 80, 2));
      else if (e < 85) chk_ch(2, ph(e, 82, 3));
      else if (e < 89) chk_ch(2, ph(e, 85, 4));
      else chk_ch(2, ph(e, 89, 2));
      check($sformatf("ready@%0d", e), 32'(div_ready),
            32'(!(e == 81 || e == 83 || e == 84 || e == 86 || e == 87 || e == 88 || e == 90)));
      check($sformatf("locked@%0d", e), 32'(locked), 0);
      div_valid = (e + 1 <= 90);
      div_value = burst_val(e + 1);
    end

    // Pending ch1 <- 7 killed by an asynchronous reset mid-period.
    div_valid = 1'b1; div_ch = 2'd1; div_value = 16'd7;
    tick();
    div_valid = 1'b0;
    check("pend_ready", 32'(div_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ce", 32'(ce_out), 0);
    check("arst_outclk", 32'(outclk), 0);
    check("arst_locked", 32'(locked), 0);
    check("arst_ready", 32'(div_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      for (int c = 0; c < NumCh; c++) chk_ch(c, ph(e, 0, 2));
      check($sformatf("post_locked@%0d", e), 32'(locked), 32'(e >= 8));
      check($sformatf("post_ready@%0d", e), 32'(div_ready), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
